// File: rtl/float_norm_16bit.sv
// float_norm_16bit: multi-cycle post-add normalizer for IEEE half precision.
// Takes the adder's raw sign/exponent/carry+mantissa fields, removes leading
// zeros one (or a few) shift steps per cycle and emits a packed half result.
//
// Handshake: a bundle transfers on a rising CLK edge where in_valid & in_ready;
// a result transfers on a rising edge where out_valid & out_ready. in_ready is
// high only in IDLE and out_valid only in DONE, so at most one bundle is in
// flight and out_result is held stable for as long as out_valid waits.
module float_norm_16bit #(
    parameter int HALF_FLOAT_W     = 16,
    parameter int SHIFTS_PER_CYCLE = 1   // 1, 2 or 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sign,
    input  logic [4:0]              in_exponent,
    input  logic [11:0]             in_mantissa,
    input  logic                    in_nan,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [HALF_FLOAT_W-1:0] out_result,
    output logic [1:0]              state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                  state_q, state_n;
    logic                    s_q, s_n;
    logic [4:0]              e_q, e_n;
    logic [11:0]             m_q, m_n;
    logic [HALF_FLOAT_W-1:0] res_q, res_n;

    // Shift-step results and carry-path exponent
    logic [4:0]  sh_e;
    logic [11:0] sh_m;
    logic [5:0]  e_inc;

    // Normal numbers keep their exponent; anything without the hidden bit
    // (or with exponent 0) is encoded as a subnormal with exponent field 0.
    function automatic logic [HALF_FLOAT_W-1:0] pack(input logic sg,
                                                     input logic [4:0] ex,
                                                     input logic [10:0] mn);
        if (mn[10] && (ex != 5'd0)) begin
            return {sg, ex, mn[9:0]};
        end
        return {sg, 5'd0, mn[9:0]};
    endfunction

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign out_result = res_q;
    assign state_dbg  = state_q;
    assign e_inc      = {1'b0, in_exponent} + 6'd1;

    // Up to SHIFTS_PER_CYCLE normalization steps; each stops at the hidden bit or at e==1
    always_comb begin
        sh_e = e_q;
        sh_m = m_q;
        for (int i = 0; i < SHIFTS_PER_CYCLE; i++) begin
            if ((sh_m[11:10] == 2'b00) && (sh_e > 5'd1)) begin
                sh_m = {sh_m[10:0], 1'b0};
                sh_e = sh_e - 5'd1;
            end
        end
    end

    // Next-state and datapath: classify on accept, normalize in SHIFT, hold in DONE
    always_comb begin
        state_n = state_q;
        s_n     = s_q;
        e_n     = e_q;
        m_n     = m_q;
        res_n   = res_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    s_n     = in_sign;
                    e_n     = in_exponent;
                    m_n     = in_mantissa;
                    state_n = DONE;
                    if (in_nan) begin
                        res_n = 16'h7E00;
                    end else if (in_mantissa == 12'd0) begin
                        // exact cancellation always yields +0
                        res_n = 16'h0000;
                    end else if (in_mantissa[11]) begin
                        // carry out: one right shift, LSB dropped without rounding
                        m_n = {1'b0, in_mantissa[11:1]};
                        e_n = e_inc[4:0];
                        if (e_inc >= 6'd31) begin
                            res_n = {in_sign, 5'h1F, 10'h000};
                        end else begin
                            res_n = {in_sign, e_inc[4:0], in_mantissa[10:1]};
                        end
                    end else if (in_mantissa[10] || (in_exponent <= 5'd1)) begin
                        res_n = pack(in_sign, in_exponent, in_mantissa[10:0]);
                    end else begin
                        state_n = SHIFT;
                    end
                end
            end
            SHIFT: begin
                e_n = sh_e;
                m_n = sh_m;
                if (sh_m[10] || (sh_e == 5'd1)) begin
                    res_n   = pack(s_q, sh_e, sh_m[10:0]);
                    state_n = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any pending result
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            s_q     <= 1'b0;
            e_q     <= 5'd0;
            m_q     <= 12'd0;
            res_q   <= '0;
        end else begin
            state_q <= state_n;
            s_q     <= s_n;
            e_q     <= e_n;
            m_q     <= m_n;
            res_q   <= res_n;
        end
    end

endmodule
